// File: rtl/spare_comb_generator.sv
// rtl/spare_comb_generator.sv - K-of-N spare selection pattern generator for BIRA
// Steps through dsss words in descending colex order, with optional one-hot rlss per word.
module spare_comb_generator #(
  parameter int N_SPARE = 8,
  parameter int K_SEL   = 4,
  parameter int N_RLSS  = 3,
  parameter int CNT_W   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         i_mode,
  input  logic               i_restart,
  input  logic               i_term_in,
  input  logic               i_test_end_in,
  input  logic               i_early_term_in,
  output logic [N_SPARE-1:0] o_dsss,
  output logic [N_RLSS-1:0]  o_rlss,
  output logic               o_start_svc,
  output logic               o_comb_valid,
  output logic [CNT_W-1:0]   o_comb_idx,
  output logic               o_gen_done,
  output logic               o_gen_busy
);

  localparam int IW = (N_SPARE > 1) ? $clog2(N_SPARE) : 1;
  localparam int RW = (N_RLSS > 1) ? $clog2(N_RLSS) : 1;

  typedef enum logic {S_RUN = 1'b0, S_DONE = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [2:0]         r_x_q;
  logic [1:0]         r_mode;
  logic [IW-1:0]      r_idx [K_SEL];
  logic [IW-1:0]      w_idx_next [K_SEL];
  logic [RW-1:0]      r_ri;
  logic [RW-1:0]      w_ri_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [N_SPARE-1:0] r_dsss;
  logic [N_RLSS-1:0]  r_rlss;
  logic               r_start;
  logic               r_valid;
  logic [CNT_W-1:0]   r_comb_idx;

  logic               w_step;
  logic               w_pair;
  logic               w_issue;
  logic               w_found;
  logic               w_adv;
  logic               w_last;
  logic [IW-1:0]      w_sel_val;
  int                 w_m_sel;
  logic [N_SPARE-1:0] w_pat;
  logic [N_RLSS-1:0]  w_rl;

  assign w_step = |({i_term_in, i_test_end_in, i_early_term_in} & ~r_x_q);
  assign w_pair = (r_mode == 2'b11);
  // In row/local mode the selection word only moves once rlss has wrapped.
  assign w_adv  = !w_pair || (r_ri == '0);
  assign w_last = w_adv && !w_found;

  always_comb begin
    w_pat = '0;
    for (int m = 0; m < K_SEL; m++) begin
      if (!(w_pair && m == 0)) w_pat[r_idx[m]] = 1'b1;
    end
    w_rl = '0;
    if (w_pair) w_rl[r_ri] = 1'b1;
  end

  // Largest index still above its floor is decremented; everything below it packs tight.
  always_comb begin
    w_found   = 1'b0;
    w_m_sel   = 0;
    w_sel_val = '0;
    for (int m = 0; m < K_SEL; m++) begin
      if (!(w_pair && m == 0) && (r_idx[m] > IW'(K_SEL - 1 - m))) begin
        w_found   = 1'b1;
        w_m_sel   = m;
        w_sel_val = r_idx[m];
      end
    end
    w_idx_next = r_idx;
    for (int j = 0; j < K_SEL; j++) begin
      if (w_adv && w_found && (j >= w_m_sel)) w_idx_next[j] = w_sel_val - IW'(j - w_m_sel + 1);
    end
    w_ri_next = r_ri;
    if (w_pair) w_ri_next = (r_ri != '0) ? (r_ri - RW'(1)) : RW'(N_RLSS - 1);
  end

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    case (r_state)
      S_RUN: begin
        if (r_mode == 2'b00) begin
          w_state_next = S_DONE;
        end else if (w_step) begin
          w_issue = 1'b1;
          if (w_last) w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_DONE;
      default: w_state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || i_restart) r_state <= S_RUN;
    else                  r_state <= w_state_next;
  end

  // Edge history survives restart so a held source cannot re-trigger afterwards.
  always_ff @(posedge clk) begin
    if (rst) r_x_q <= '0;
    else     r_x_q <= {i_term_in, i_test_end_in, i_early_term_in};
  end

  always_ff @(posedge clk) begin
    if (rst || i_restart) begin
      r_mode <= i_mode;
      for (int m = 0; m < K_SEL; m++) r_idx[m] <= IW'(N_SPARE - 1 - m);
      r_ri   <= RW'(N_RLSS - 1);
      r_cnt  <= '0;
    end else if (w_issue) begin
      r_idx <= w_idx_next;
      r_ri  <= w_ri_next;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_restart) begin
      r_start    <= 1'b0;
      r_valid    <= 1'b0;
      r_dsss     <= '0;
      r_rlss     <= '0;
      r_comb_idx <= '0;
    end else begin
      r_start <= w_step;
      r_valid <= w_issue;
      r_dsss  <= w_issue ? w_pat : '0;
      r_rlss  <= w_issue ? w_rl : '0;
      if (w_issue) r_comb_idx <= r_cnt;
    end
  end

  assign o_dsss       = r_dsss;
  assign o_rlss       = r_rlss;
  assign o_start_svc  = r_start;
  assign o_comb_valid = r_valid;
  assign o_comb_idx   = r_comb_idx;
  assign o_gen_done   = (r_state == S_DONE);
  assign o_gen_busy   = (r_state == S_RUN);

endmodule

// File: tb/tb_spare_comb_generator.sv
// tb/tb_spare_comb_generator.sv - bench for spare_comb_generator
module tb_spare_comb_generator;

  typedef struct {
    logic       valid;
    logic [7:0] d;
    logic [2:0] r;
    int         idx;
  } exp_t;

  typedef struct {
    logic [2:0] src;
    int         hi;
    logic [7:0] exp_d;
    int         exp_idx;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] i_mode = 2'b01;
  logic       i_restart = 1'b0;
  logic [2:0] srcs = 3'b000;
  logic [7:0] o_dsss;
  logic [2:0] o_rlss;
  logic       o_start_svc;
  logic       o_comb_valid;
  logic [9:0] o_comb_idx;
  logic       o_gen_done;
  logic       o_gen_busy;

  int         n_tests = 0;
  int         n_fail = 0;
  int         exp_hold = 0;
  exp_t       sb[$];
  logic [7:0] pat_d[$];
  logic [2:0] pat_r[$];
  int         m_cnt = 0;
  bit         m_done = 1'b0;

  always #5 clk = ~clk;

  spare_comb_generator #(.N_SPARE(8), .K_SEL(4), .N_RLSS(3), .CNT_W(10)) dut (
    .clk(clk), .rst(rst), .i_mode(i_mode), .i_restart(i_restart),
    .i_term_in(srcs[2]), .i_test_end_in(srcs[1]), .i_early_term_in(srcs[0]),
    .o_dsss(o_dsss), .o_rlss(o_rlss), .o_start_svc(o_start_svc), .o_comb_valid(o_comb_valid),
    .o_comb_idx(o_comb_idx), .o_gen_done(o_gen_done), .o_gen_busy(o_gen_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Descending numeric order over words with the right popcount is descending colex.
  function automatic void build(input bit pair);
    logic [7:0] wv;
    pat_d.delete();
    pat_r.delete();
    for (int w = 255; w >= 0; w--) begin
      wv = 8'(w);
      if (pair) begin
        if (!wv[7] && $countones(wv) == 3) begin
          for (int k = 0; k < 3; k++) begin
            pat_d.push_back(wv);
            pat_r.push_back(3'(3'b100 >> k));
          end
        end
      end else if ($countones(wv) == 4) begin
        pat_d.push_back(wv);
        pat_r.push_back(3'b000);
      end
    end
  endfunction

  function automatic void model_reset(input logic [1:0] mode);
    build(mode == 2'b11);
    m_cnt  = 0;
    m_done = (mode == 2'b00);
  endfunction

  task automatic push_step();
    exp_t e;
    if (!m_done) begin
      e.valid = 1'b1;
      e.d     = pat_d[m_cnt];
      e.r     = pat_r[m_cnt];
      e.idx   = m_cnt;
      m_cnt++;
      if (m_cnt == pat_d.size()) m_done = 1'b1;
    end else begin
      e.valid = 1'b0;
      e.d     = 8'h00;
      e.r     = 3'b000;
      e.idx   = (m_cnt == 0) ? 0 : m_cnt - 1;
    end
    sb.push_back(e);
  endtask

  task automatic drive(input logic [2:0] mask, input int hi);
    srcs = mask;
    repeat (hi) @(negedge clk);
    srcs = 3'b000;
    repeat (2) @(negedge clk);
  endtask

  task automatic restart_seq(input logic [1:0] mode, input logic [2:0] mask);
    i_mode    = mode;
    i_restart = 1'b1;
    srcs      = mask;
    exp_hold  = 0;
    model_reset(mode);
    @(negedge clk);
    i_restart = 1'b0;
    srcs      = 3'b000;
    repeat (2) @(negedge clk);
  endtask

  task automatic rst_seq(input logic [1:0] mode);
    i_mode   = mode;
    rst      = 1'b1;
    exp_hold = 0;
    @(negedge clk);
    rst = 1'b0;
    model_reset(mode);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (o_start_svc === 1'b1) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pulse: got dsss %0h idx %0d expected no pulse", o_dsss, o_comb_idx);
        end else begin
          e = sb.pop_front();
          chk("comb_valid", 32'(o_comb_valid), 32'(e.valid));
          chk("dsss", 32'(o_dsss), 32'(e.d));
          chk("rlss", 32'(o_rlss), 32'(e.r));
          chk("comb_idx", 32'(o_comb_idx), 32'(e.idx));
          exp_hold = e.idx;
        end
      end else begin
        chk("idle_outputs", 32'({o_comb_valid, o_rlss, o_dsss, o_comb_idx}),
            32'({1'b0, 3'b000, 8'h00, 10'(exp_hold)}));
      end
    end
  end

  initial begin
    #60000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[70];
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset(2'b01);
    chk("reset_busy", 32'(o_gen_busy), 32'd1);
    chk("reset_done", 32'(o_gen_done), 32'd0);
    chk("reset_start", 32'(o_start_svc), 32'd0);
    chk("reset_valid", 32'(o_comb_valid), 32'd0);
    chk("reset_dsss", 32'(o_dsss), 32'd0);
    chk("reset_idx", 32'(o_comb_idx), 32'd0);

    for (int i = 0; i < 70; i++) begin
      vecs[i].src     = 3'((i % 7) + 1);
      vecs[i].hi      = 1;
      vecs[i].exp_d   = pat_d[i];
      vecs[i].exp_idx = i;
    end
    for (int i = 0; i < 70; i++) begin
      exp_t e;
      e.valid = 1'b1;
      e.d     = vecs[i].exp_d;
      e.r     = 3'b000;
      e.idx   = vecs[i].exp_idx;
      sb.push_back(e);
      m_cnt++;
      if (m_cnt == pat_d.size()) m_done = 1'b1;
      if (i == 69) chk("done_before_last", 32'(o_gen_done), 32'd0);
      drive(vecs[i].src, vecs[i].hi);
    end
    chk("done_after_70", 32'(o_gen_done), 32'd1);
    chk("busy_after_70", 32'(o_gen_busy), 32'd0);

    push_step();
    drive(3'b100, 1);
    chk("idx_hold_71", 32'(o_comb_idx), 32'd69);
    chk("done_hold_71", 32'(o_gen_done), 32'd1);

    restart_seq(2'b01, 3'b000);
    chk("restart_busy", 32'(o_gen_busy), 32'd1);
    for (int i = 0; i < 20; i++) begin
      push_step();
      drive(3'b010, 1);
    end
    restart_seq(2'b01, 3'b100);
    chk("restart_step_idx", 32'(o_comb_idx), 32'd0);
    push_step();
    drive(3'b001, 1);
    i_mode = 2'b11;
    push_step();
    drive(3'b001, 1);

    restart_seq(2'b11, 3'b000);
    push_step();
    drive(3'b101, 1);
    push_step();
    drive(3'b001, 10);
    push_step();
    drive(3'b111, 1);
    for (int i = 0; i < 200 && !m_done; i++) begin
      push_step();
      drive(3'(1 << (i % 3)), 1);
    end
    chk("pair_count", 32'(m_cnt), 32'd105);
    chk("pair_done", 32'(o_gen_done), 32'd1);
    push_step();
    drive(3'b010, 1);

    rst_seq(2'b00);
    repeat (2) @(negedge clk);
    chk("mode0_done", 32'(o_gen_done), 32'd1);
    chk("mode0_busy", 32'(o_gen_busy), 32'd0);
    push_step();
    drive(3'b100, 1);

    rst_seq(2'b01);
    push_step();
    srcs = 3'b001;
    @(negedge clk);
    rst      = 1'b1;
    srcs     = 3'b000;
    exp_hold = 0;
    @(negedge clk);
    rst = 1'b0;
    model_reset(2'b01);
    chk("rst_abort_start", 32'(o_start_svc), 32'd0);
    chk("rst_abort_dsss", 32'(o_dsss), 32'd0);
    chk("rst_abort_busy", 32'(o_gen_busy), 32'd1);
    repeat (2) @(negedge clk);

    rst      = 1'b1;
    srcs     = 3'b010;
    exp_hold = 0;
    @(negedge clk);
    rst  = 1'b0;
    srcs = 3'b000;
    model_reset(2'b01);
    repeat (2) @(negedge clk);
    push_step();
    drive(3'b100, 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
